unified_mem_arbiter: RTL and testbench
======================================

# unified_mem_arbiter

Arbiter that shares one single-ported unified instruction/data memory between the pipeline's fetch stage (IF) and memory stage (MEM). It grants the port to one requester at a time and drives the memory handshake. It returns read data and completion strobes to the owning stage, and generates fetch and memory-stage stall requests for the hazard logic. It sits between the pipelined datapath and the memory, replacing separate instruction/data memories.

## Interface
- `ADDR_W`, 32, address width.
- `DATA_W`, 32, data width.
- `STARVE_MAX`, 4, consecutive data grants allowed while a fetch waits; range 1–15.
- `TIMEOUT_CYC`, 64, busy cycles before abort; used only with the timeout feature.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; asynchronous, active-low.
- `if_req`  in  1  fetch request; held high with stable `if_addr` until `if_valid`.
- `if_addr`  in  ADDR_W  fetch address.
- `if_rdata`  out  DATA_W  fetch data; meaningful only while `if_valid`.
- `if_valid`  out  1  fetch completion strobe.
- `dm_req`  in  1  data request; held high with stable `dm_we`, `dm_addr` and `dm_wdata` until `dm_valid`.
- `dm_we`  in  1  1 = write, 0 = read.
- `dm_addr`  in  ADDR_W  data address.
- `dm_wdata`  in  DATA_W  store data.
- `dm_rdata`  out  DATA_W  load data; meaningful only while `dm_valid`.
- `dm_valid`  out  1  data completion strobe, for reads and writes.
- `mem_req`  out  1  memory request.
- `mem_we`  out  1  memory write enable.
- `mem_addr`  out  ADDR_W  memory address.
- `mem_wdata`  out  DATA_W  memory write data.
- `mem_rdata`  in  DATA_W  memory read data; valid when `mem_ready` is high.
- `mem_ready`  in  1  memory completion; sampled only while `mem_req` is high.
- `stall_f`  out  1  fetch stall request to the hazard unit.
- `stall_m`  out  1  memory-stage stall request to the hazard unit.
- `err`  out  1  one-cycle timeout abort pulse.

## Operation
- FSM states: IDLE, IF_BUSY, DM_BUSY. Reset enters IDLE.
- Arbitration in IDLE:
  - If `dm_req` and `starve_cnt` < `STARVE_MAX`, go to DM_BUSY.
  - Otherwise, if `if_req`, go to IF_BUSY.
  - Otherwise, if `dm_req`, go to DM_BUSY.
  - Otherwise, stay in IDLE.
- On each grant, latch address, we and wdata into `mem_addr`, `mem_we` and `mem_wdata`. Fetch grants force `mem_we` = 0 and `mem_wdata` = 0.
- `mem_req` = 1 in either BUSY state, otherwise 0. It is a registered state decode with no combinational path from requester inputs.
- BUSY with `mem_ready` = 1 is the completion cycle:
  - Owner strobe is combinational: `if_valid` = IF_BUSY & `mem_ready`; `dm_valid` = DM_BUSY & `mem_ready`.
  - Owner rdata = `mem_rdata` in the same cycle.
  - The next state is IDLE.
- `if_rdata` and `dm_rdata` are 0 when their strobe is low.
- `starve_cnt`, 4 bits:
  - +1 on each DM grant made while `if_req` = 1, saturating at 15.
  - Clears to 0 on an IF grant, or in any IDLE cycle with `if_req` = 0.
- Stall outputs: `stall_f` = `if_req` & ~`if_valid`; `stall_m` = `dm_req` & ~`dm_valid`.
- Simultaneous `if_req` and `dm_req` in IDLE: data wins unless the starvation limit has been reached.
- `mem_ready` outside BUSY is ignored.
- A requester dropping `req` before its strobe is a protocol violation. The arbiter still completes the memory access and discards the result; no strobe is emitted.
- Reset mid-transaction: FSM goes to IDLE and all outputs drop immediately. The memory must tolerate the abandoned request.

## Timing
- Reset values: `mem_req`, `mem_we`, `if_valid`, `dm_valid`, `stall_f`, `stall_m` and `err` = 0; `mem_addr`, `mem_wdata`, `if_rdata` and `dm_rdata` = 0; `starve_cnt` = 0. `stall_f` and `stall_m` rise combinationally with any request, including during reset release.
- Request sampled in IDLE at cycle N → `mem_req` high from N+1.
- With a zero-wait memory (`mem_ready` high the first cycle `mem_req` is high), the strobe occurs at N+1.
- Per-access occupancy is 1 IDLE cycle plus the memory latency. Back-to-back accesses always have one IDLE cycle between them.
- A requester may present its next request in the cycle after its strobe.

## Configuration
- Macro `UNIFIED_MEM_ARB_TIMEOUT_EN`.
- Defined:
  - An 8-bit busy counter clears on grant and increments each BUSY cycle without `mem_ready`.
  - On reaching `TIMEOUT_CYC`, the FSM returns to IDLE.
  - The owner strobe pulses with rdata = 32'hDEADBEEF, and `err` pulses for that same cycle.
  - A store that times out is not retried.
- Undefined: no counter; `err` is tied to 0; a hung memory stalls forever.

## Test plan
- Fetch only, zero-wait memory, `if_addr` = 0x0, 0x4, 0x8, `mem_rdata` = addr+0x100 → `if_valid` on every other cycle with rdata 0x100, 0x104, 0x108; `stall_f` low only on strobe cycles.
- `if_req` and `dm_req` both high, `dm_we` = 0, `dm_addr` = 0x40 → DM granted first; `dm_valid` with data; IF granted next and `if_valid` follows.
- `dm_req` held continuously with fetch pending, `STARVE_MAX` = 4 → exactly 4 DM grants, then 1 IF grant; `starve_cnt` returns to 0.
- Store: `dm_we` = 1, `dm_addr` = 0x80, `dm_wdata` = 0x12345678, `mem_ready` delayed 3 cycles → `mem_req`/`mem_we` high for 3 cycles with a stable address; `dm_valid` and `stall_m` release in the ready cycle.
- `rst` asserted in the second cycle of DM_BUSY → `mem_req` = 0 immediately; FSM in IDLE; the next request after release is granted normally.
- With `UNIFIED_MEM_ARB_TIMEOUT_EN`, `TIMEOUT_CYC` = 8, `mem_ready` stuck at 0 on a fetch → `if_valid` with rdata 0xDEADBEEF and `err` pulse 8 cycles after `mem_req` rises.

Source files
------------

// File: rtl/unified_mem_arbiter.sv
// rtl/unified_mem_arbiter.sv - shares one memory port between fetch and memory stages.
// Optional busy timeout: UNIFIED_MEM_ARB_TIMEOUT_EN.
module unified_mem_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int STARVE_MAX  = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_valid,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              stall_f,
  output logic              stall_m,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, IF_BUSY, DM_BUSY} state_e;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_e            state_q, state_d;
  logic [3:0]        starve_q, starve_d;
  logic              mem_req_q, mem_we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              busy, abort, done;
  logic [DATA_W-1:0] rdata_src;

  assign busy = (state_q != IDLE);

`ifdef UNIFIED_MEM_ARB_TIMEOUT_EN
  logic [7:0] busy_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_cnt_q <= 8'd0;
    end else if (!busy) begin
      busy_cnt_q <= 8'd0;
    end else if (!mem_ready) begin
      busy_cnt_q <= busy_cnt_q + 8'd1;
    end
  end

  assign abort = busy && !mem_ready && (busy_cnt_q == 8'(TIMEOUT_CYC));
`else
  logic [7:0] unused_timeout_cyc;
  assign unused_timeout_cyc = 8'(TIMEOUT_CYC);
  assign abort = 1'b0;
`endif

  assign done = busy && (mem_ready || abort);

  // Data wins the port unless the fetch has already waited out STARVE_MAX data grants.
  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    case (state_q)
      IDLE: begin
        if (dm_req && (starve_q < STARVE_LIM)) state_d = DM_BUSY;
        else if (if_req)                       state_d = IF_BUSY;
        else if (dm_req)                       state_d = DM_BUSY;
        if (!if_req || (state_d == IF_BUSY))                  starve_d = 4'd0;
        else if ((state_d == DM_BUSY) && (starve_q != 4'hF)) starve_d = starve_q + 4'd1;
      end
      default: if (done) state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      starve_q  <= 4'd0;
      mem_req_q <= 1'b0;
      mem_we_q  <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      starve_q  <= starve_d;
      mem_req_q <= (state_d != IDLE);
      if ((state_q == IDLE) && (state_d == DM_BUSY)) begin
        addr_q   <= dm_addr;
        mem_we_q <= dm_we;
        wdata_q  <= dm_wdata;
      end else if ((state_q == IDLE) && (state_d == IF_BUSY)) begin
        addr_q   <= if_addr;
        mem_we_q <= 1'b0;
        wdata_q  <= '0;
      end else if (done) begin
        mem_we_q <= 1'b0;
      end
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  // A requester that dropped its request mid-access gets no strobe.
  assign rdata_src = abort ? DATA_W'(32'hDEADBEEF) : mem_rdata;
  assign if_valid  = (state_q == IF_BUSY) && done && if_req;
  assign dm_valid  = (state_q == DM_BUSY) && done && dm_req;
  assign if_rdata  = if_valid ? rdata_src : '0;
  assign dm_rdata  = dm_valid ? rdata_src : '0;
  assign stall_f   = if_req && !if_valid;
  assign stall_m   = dm_req && !dm_valid;
  assign err       = abort;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb/tb_unified_mem_arbiter.sv - self-checking bench for unified_mem_arbiter.
module tb_unified_mem_arbiter;
  localparam int SMAX = 4;
  localparam int TCYC = 8;

  logic        clk = 1'b0, rst = 1'b0;
  logic        if_req = 1'b0, dm_req = 1'b0, dm_we = 1'b0;
  logic [31:0] if_addr = '0, dm_addr = '0, dm_wdata = '0;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ready = 1'b0;
  logic        if_valid, dm_valid, mem_req, mem_we, stall_f, stall_m, err;

  int checks = 0, failures = 0;
  int lat = 1, cur_lat = 1, busy_cyc = 0;
  bit noise = 0, rand_lat = 0, hang = 0;
  logic [31:0] mem_arr   [logic [31:0]];
  logic [31:0] model_mem [logic [31:0]];

  always #5 clk = ~clk;

  unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(SMAX), .TIMEOUT_CYC(TCYC)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_valid(dm_valid),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .stall_f(stall_f), .stall_m(stall_m), .err(err)
  );

  function automatic logic [31:0] rd_mem(input logic [31:0] a);
    return mem_arr.exists(a) ? mem_arr[a] : a + 32'h100;
  endfunction

  function automatic logic [31:0] rd_model(input logic [31:0] a);
    return model_mem.exists(a) ? model_mem[a] : a + 32'h100;
  endfunction

  // Memory: answers after a configurable number of request cycles, noise while idle.
  always @(posedge clk) begin
    #1;
    if (mem_req) begin
      if (busy_cyc == 0) cur_lat = rand_lat ? int'($urandom_range(1, 4)) : lat;
      busy_cyc++;
      mem_ready = (busy_cyc >= cur_lat) && !hang;
      mem_rdata = mem_ready ? rd_mem(mem_addr) : $urandom;
    end else begin
      busy_cyc  = 0;
      mem_ready = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      mem_rdata = $urandom;
    end
  end

  always @(negedge clk) if (mem_req && mem_ready && mem_we) mem_arr[mem_addr] = mem_wdata;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    @(negedge clk); @(negedge clk);
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL rst_mem_req got=%b exp=0", mem_req); end
    checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL rst_mem_we got=%b exp=0", mem_we); end
    checks++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin failures++; $display("FAIL rst_mem_bus got=%h/%h exp=0/0", mem_addr, mem_wdata); end
    checks++; if ({if_valid, dm_valid, err} !== 3'b000) begin failures++; $display("FAIL rst_strobes got=%b exp=000", {if_valid, dm_valid, err}); end
    checks++; if (if_rdata !== 32'h0 || dm_rdata !== 32'h0) begin failures++; $display("FAIL rst_rdata got=%h/%h exp=0/0", if_rdata, dm_rdata); end
    checks++; if ({stall_f, stall_m} !== 2'b00) begin failures++; $display("FAIL rst_stall_idle got=%b exp=00", {stall_f, stall_m}); end
    if_req = 1'b1; dm_req = 1'b1; #1;
    checks++; if ({stall_f, stall_m} !== 2'b11) begin failures++; $display("FAIL rst_stall_req got=%b exp=11", {stall_f, stall_m}); end
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL rst_hold_mem_req got=%b exp=0", mem_req); end
    if_req = 1'b0; dm_req = 1'b0;
    tick(); rst = 1'b1;
  endtask

  task automatic test_fetch_only();
    lat = 1;
    for (int i = 0; i < 3; i++) begin
      tick(); if_req = 1'b1; if_addr = 32'(i * 4);
      @(negedge clk);
      checks++; if (if_valid !== 1'b0 || stall_f !== 1'b1 || mem_req !== 1'b0) begin failures++; $display("FAIL fetch_idle[%0d] got valid=%b stall=%b req=%b exp 0/1/0", i, if_valid, stall_f, mem_req); end
      tick();
      @(negedge clk);
      checks++; if (if_valid !== 1'b1 || stall_f !== 1'b0) begin failures++; $display("FAIL fetch_strobe[%0d] got valid=%b stall=%b exp 1/0", i, if_valid, stall_f); end
      checks++; if (if_rdata !== 32'h100 + 32'(i * 4)) begin failures++; $display("FAIL fetch_rdata[%0d] got=%h exp=%h", i, if_rdata, 32'h100 + 32'(i * 4)); end
    end
    tick(); if_req = 1'b0;
  endtask

  task automatic test_priority();
    lat = 1;
    if_req = 1'b1; if_addr = 32'h200; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h40;
    @(negedge clk);
    checks++; if ({stall_f, stall_m} !== 2'b11) begin failures++; $display("FAIL prio_stalls got=%b exp=11", {stall_f, stall_m}); end
    tick();
    @(negedge clk);
    checks++; if (dm_valid !== 1'b1 || if_valid !== 1'b0) begin failures++; $display("FAIL prio_dm_first got dm=%b if=%b exp 1/0", dm_valid, if_valid); end
    checks++; if (dm_rdata !== 32'h140 || mem_addr !== 32'h40) begin failures++; $display("FAIL prio_dm_data got=%h@%h exp=140@40", dm_rdata, mem_addr); end
    tick(); dm_req = 1'b0;
    tick();
    @(negedge clk);
    checks++; if (if_valid !== 1'b1 || if_rdata !== 32'h300 || mem_addr !== 32'h200) begin failures++; $display("FAIL prio_if_next got v=%b d=%h a=%h exp 1/300/200", if_valid, if_rdata, mem_addr); end
    tick(); if_req = 1'b0;
  endtask

  task automatic test_starvation();
    int dm_n;
    bit if_seen;
    lat = 1;
    if_req = 1'b1; if_addr = 32'h10; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h20;
    for (int r = 0; r < 2; r++) begin
      dm_n = 0; if_seen = 0;
      for (int c = 0; c < 30 && !if_seen; c++) begin
        @(negedge clk);
        if (dm_valid) dm_n++;
        if (if_valid) if_seen = 1;
        if (!if_seen) tick();
      end
      checks++; if (!if_seen) begin failures++; $display("FAIL starve_if_grant[%0d] got=none exp=if_valid", r); end
      checks++; if (dm_n != SMAX) begin failures++; $display("FAIL starve_dm_count[%0d] got=%0d exp=%0d", r, dm_n, SMAX); end
      tick();
    end
    if_req = 1'b0; dm_req = 1'b0;
  endtask

  task automatic test_store();
    lat = 3;
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h80; dm_wdata = 32'h12345678;
    @(negedge clk);
    checks++; if (mem_req !== 1'b0 || stall_m !== 1'b1) begin failures++; $display("FAIL store_idle got req=%b stall=%b exp 0/1", mem_req, stall_m); end
    for (int k = 1; k <= 3; k++) begin
      tick();
      @(negedge clk);
      checks++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h80 || mem_wdata !== 32'h12345678) begin failures++; $display("FAIL store_bus[%0d] got req=%b we=%b a=%h d=%h exp 1/1/80/12345678", k, mem_req, mem_we, mem_addr, mem_wdata); end
      checks++; if (dm_valid !== (k == 3) || stall_m !== (k != 3)) begin failures++; $display("FAIL store_done[%0d] got valid=%b stall=%b exp %b/%b", k, dm_valid, stall_m, k == 3, k != 3); end
    end
    lat = 1;
    tick(); dm_we = 1'b0;
    @(negedge clk);
    checks++; if (mem_req !== 1'b0 || mem_we !== 1'b0) begin failures++; $display("FAIL store_release got req=%b we=%b exp 0/0", mem_req, mem_we); end
    tick();
    @(negedge clk);
    checks++; if (dm_valid !== 1'b1 || dm_rdata !== 32'h12345678) begin failures++; $display("FAIL store_readback got v=%b d=%h exp 1/12345678", dm_valid, dm_rdata); end
    tick(); dm_req = 1'b0;
  endtask

  task automatic test_reset_mid();
    lat = 5;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h44;
    tick(); tick();
    #2 rst = 1'b0; #1;
    checks++; if (mem_req !== 1'b0 || dm_valid !== 1'b0 || mem_addr !== 32'h0) begin failures++; $display("FAIL midrst_drop got req=%b v=%b a=%h exp 0/0/0", mem_req, dm_valid, mem_addr); end
    checks++; if (stall_m !== 1'b1) begin failures++; $display("FAIL midrst_stall got=%b exp=1", stall_m); end
    lat = 1;
    tick(); rst = 1'b1;
    @(negedge clk);
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL midrst_idle got=%b exp=0", mem_req); end
    tick();
    @(negedge clk);
    checks++; if (mem_req !== 1'b1 || dm_valid !== 1'b1 || dm_rdata !== 32'h144 || mem_addr !== 32'h44) begin failures++; $display("FAIL midrst_regrant got req=%b v=%b d=%h a=%h exp 1/1/144/44", mem_req, dm_valid, dm_rdata, mem_addr); end
    tick(); dm_req = 1'b0;
  endtask

`ifdef UNIFIED_MEM_ARB_TIMEOUT_EN
  task automatic test_timeout();
    hang = 1;
    if_req = 1'b1; if_addr = 32'h300;
    tick();
    for (int k = 1; k <= TCYC; k++) begin
      @(negedge clk);
      checks++; if (if_valid !== 1'b0 || err !== 1'b0 || mem_req !== 1'b1) begin failures++; $display("FAIL tmo_wait[%0d] got v=%b err=%b req=%b exp 0/0/1", k, if_valid, err, mem_req); end
      tick();
    end
    @(negedge clk);
    checks++; if (if_valid !== 1'b1 || err !== 1'b1 || if_rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL tmo_abort got v=%b err=%b d=%h exp 1/1/deadbeef", if_valid, err, if_rdata); end
    hang = 0;
    tick(); if_req = 1'b0;
    @(negedge clk);
    checks++; if (mem_req !== 1'b0 || err !== 1'b0) begin failures++; $display("FAIL tmo_idle got req=%b err=%b exp 0/0", mem_req, err); end
  endtask
`endif

  task automatic test_random();
    int own = 0, m_cnt = 0;
    logic [31:0] m_a = '0, m_d = '0, e_rd;
    logic m_w = 1'b0;
    bit if_got = 0, dm_got = 0, rdy, e_ifv, e_dmv;
    noise = 1; rand_lat = 1;
    for (int cyc = 0; cyc < 400; cyc++) begin
      tick();
      if (!if_req || if_got) begin
        if_req = ($urandom_range(0, 1) == 0); if_addr = 32'h1000 | (32'($urandom_range(0, 15)) << 2);
      end
      if (!dm_req || dm_got) begin
        dm_req = ($urandom_range(0, 1) == 0); dm_we = 1'($urandom_range(0, 1));
        dm_addr = 32'h1000 | (32'($urandom_range(0, 15)) << 2); dm_wdata = $urandom;
      end
      @(negedge clk);
      rdy   = mem_ready;
      e_ifv = (own == 1) && rdy;
      e_dmv = (own == 2) && rdy;
      e_rd  = rd_model(m_a);
      checks++; if (mem_req !== (own != 0)) begin failures++; $display("FAIL rnd_mem_req@%0d got=%b exp=%b", cyc, mem_req, own != 0); end
      checks++; if (if_valid !== e_ifv || dm_valid !== e_dmv) begin failures++; $display("FAIL rnd_strobe@%0d got if=%b dm=%b exp %b/%b", cyc, if_valid, dm_valid, e_ifv, e_dmv); end
      checks++; if (if_rdata !== (e_ifv ? e_rd : 32'h0) || dm_rdata !== (e_dmv ? e_rd : 32'h0)) begin failures++; $display("FAIL rnd_rdata@%0d got if=%h dm=%h exp_data=%h", cyc, if_rdata, dm_rdata, e_rd); end
      checks++; if (stall_f !== (if_req && !e_ifv) || stall_m !== (dm_req && !e_dmv)) begin failures++; $display("FAIL rnd_stall@%0d got f=%b m=%b", cyc, stall_f, stall_m); end
      if (own != 0) begin
        checks++; if (mem_addr !== m_a || mem_we !== m_w || mem_wdata !== m_d) begin failures++; $display("FAIL rnd_bus@%0d got a=%h we=%b d=%h exp a=%h we=%b d=%h", cyc, mem_addr, mem_we, mem_wdata, m_a, m_w, m_d); end
      end
      if_got = if_valid; dm_got = dm_valid;
      if (own != 0) begin
        if (rdy) begin
          if (own == 2 && m_w) model_mem[m_a] = m_d;
          own = 0;
        end
      end else if (dm_req && (m_cnt < SMAX || !if_req)) begin
        own = 2; m_a = dm_addr; m_w = dm_we; m_d = dm_wdata;
        m_cnt = if_req ? ((m_cnt < 15) ? m_cnt + 1 : 15) : 0;
      end else if (if_req) begin
        own = 1; m_a = if_addr; m_w = 1'b0; m_d = '0; m_cnt = 0;
      end else begin
        m_cnt = 0;
      end
    end
    for (int c = 0; c < 20 && (if_req || dm_req || mem_req); c++) begin
      tick();
      if (if_got) if_req = 1'b0;
      if (dm_got) dm_req = 1'b0;
      @(negedge clk);
      if_got = if_valid; dm_got = dm_valid;
      if (!if_req && !dm_req) begin tick(); @(negedge clk); end
    end
    checks++; if (mem_req !== 1'b0 || if_req || dm_req) begin failures++; $display("FAIL rnd_drain got req=%b exp=0", mem_req); end
    noise = 0; rand_lat = 0;
  endtask

  initial begin
    test_reset();
    test_fetch_only();
    test_priority();
    test_starvation();
    test_store();
    test_reset_mid();
`ifdef UNIFIED_MEM_ARB_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
